dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter D_SIZE, default 32, data word width in bits (multiple of 8, at least 16).
REQ-002 SHALL have parameter ADDR_LINE, default 12, byte-address width.
REQ-003 SHALL have parameter D_MEM, default 1024, depth in words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, extra access latency in cycles (0..15).
REQ-005 SHALL have port clk, input, 1 bit, single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1 bit, request present.
REQ-008 SHALL have port req_ready, output, 1 bit, request accepted when high with req_valid.
REQ-009 SHALL have port req_we, input, 1 bit, 1 = store, 0 = load.
REQ-010 SHALL have port req_size, input, 2 bits, 00 byte, 01 half, 10 word (D_SIZE), 11 illegal.
REQ-011 SHALL have port req_unsigned, input, 1 bit, load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port req_addr, input, ADDR_LINE bits, byte address.
REQ-013 SHALL have port req_wdata, input, D_SIZE bits, store data, right-aligned.
REQ-014 SHALL have port resp_valid, output, 1 bit, response present.
REQ-015 SHALL have port resp_ready, input, 1 bit, response consumed when high with resp_valid.
REQ-016 SHALL have port resp_rdata, output, D_SIZE bits, extended load data; 0 for stores and errors.
REQ-017 SHALL have port resp_err, output, 1 bit, misaligned, out-of-range or illegal-size access.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; one outstanding request maximum.
REQ-019 IDLE with req_valid SHALL latch the request, then enter WAIT with counter = WAIT_CYCLES, or RESP directly when WAIT_CYCLES = 0.
REQ-020 WAIT SHALL decrement the counter each cycle and enter RESP after it reaches 1; resp_valid SHALL rise exactly 1+WAIT_CYCLES cycles after acceptance.
REQ-021 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready; on handshake SHALL return to IDLE (no same-cycle new accept).
REQ-022 Word index SHALL be req_addr >> log2(D_SIZE/8); byte lane SHALL be the low log2(D_SIZE/8) address bits.
REQ-023 Error SHALL be flagged for: size 11; half with addr[0]=1; word with nonzero lane bits; word index >= D_MEM.
REQ-024 A store SHALL commit on the edge entering RESP, updating only addressed lanes (1, 2 or D_SIZE/8 bytes); other bytes preserved.
REQ-025 An erroring store SHALL not modify memory; an erroring load SHALL return resp_rdata = 0.
REQ-026 A load SHALL sample the array on the edge entering RESP, so it returns data of any previously completed store.
REQ-027 Load byte/half data SHALL be shifted to bit 0 and sign- or zero-extended to D_SIZE per req_unsigned; word loads are unmodified.
REQ-028 Request inputs changing after acceptance SHALL have no effect on the in-flight access.

Reset
REQ-029 When reset = 0 at a rising edge: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, all memory words 0.
REQ-030 Reset during WAIT or RESP SHALL abort the access with no memory write and no response.
REQ-031 req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Shared package (struct.sv) SHALL hold D_SIZE/ADDR_LINE/D_MEM defaults, mem_t, size enum (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state enum.
REQ-033 Storage SHALL be sub-module dmem_array (byte-enabled write, synchronous read, synchronous clear); FSM, alignment check and extension in dmem_ctrl.

Verification (D_SIZE=32, WAIT_CYCLES=2)
REQ-034 Store word 0xDEADBEEF @0x010, then load word @0x010 -> resp_valid 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-035 Store byte 0x80 @0x013, load signed byte @0x013 -> 0xFFFFFF80; unsigned -> 0x00000080; word @0x010 -> 0x80ADBEEF.
REQ-036 Load half @0x011 and word @0x012 -> err 1, rdata 0; subsequent word load @0x010 unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready 0 throughout; accept next request only after handshake.
REQ-038 Assert reset in WAIT of a store 0x12345678 @0x020 -> no response; later load @0x020 -> 0x00000000.
REQ-039 Word store with index D_MEM (addr 0x1000 at ADDR_LINE=13) -> err 1, memory unchanged.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller slice.
//   - default geometry (word width, byte-address width, depth)
//   - mem_t    : one storage word at the default width
//   - size_e   : access size encoding carried on req_size
//   - state_e  : controller FSM states
package dmem_ctrl_pkg;

  localparam int D_SIZE_DEF    = 32;
  localparam int ADDR_LINE_DEF = 12;
  localparam int D_MEM_DEF     = 1024;

  typedef logic [D_SIZE_DEF-1:0] mem_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_ctrl_array.sv
// dmem_array: word-organised storage with per-byte write enables.
//   clk, reset   : rising-edge clock, synchronous active-low clear of all words
//   we, be       : write strobe and byte-lane enables
//   addr         : word index shared by read and write
//   wdata        : lane-aligned write data
//   re           : read strobe; rdata updates on the edge where re is high
//   rdata        : registered read data, held until the next read
module dmem_array
  import dmem_ctrl_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DEF,
  parameter int D_MEM  = D_MEM_DEF,
  parameter int AW     = $clog2(D_MEM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [D_SIZE/8-1:0] be,
  input  logic [AW-1:0]     addr,
  input  logic [D_SIZE-1:0] wdata,
  input  logic              re,
  output logic [D_SIZE-1:0] rdata
);

  localparam int NB = D_SIZE / 8;

  logic [D_SIZE-1:0] mem_q [D_MEM];
  logic [D_SIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < D_MEM; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      if (re) rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store controller in front of dmem_array.
//   clk, reset                 : rising-edge clock, synchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only while idle)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                  : access description, latched on acceptance
//   resp_valid/resp_ready      : response handshake
//   resp_rdata                 : extended load data, 0 for stores and errors
//   resp_err                   : misaligned, out-of-range or illegal size
//
// state   | meaning
// IDLE    | ready for a request
// WAIT    | counting down access latency
// RESP    | response held until resp_ready
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int D_SIZE      = D_SIZE_DEF,
  parameter int ADDR_LINE   = ADDR_LINE_DEF,
  parameter int D_MEM       = D_MEM_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_LINE-1:0] req_addr,
  input  logic [D_SIZE-1:0]    req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [D_SIZE-1:0]    resp_rdata,
  output logic                 resp_err
);

  localparam int NB     = D_SIZE / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = ADDR_LINE - LANE_W;
  localparam int MEM_AW = $clog2(D_MEM);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  lat_we_q, lat_we_d;
  size_e                 lat_size_q, lat_size_d;
  logic                  lat_unsigned_q, lat_unsigned_d;
  logic [ADDR_LINE-1:0]  lat_addr_q, lat_addr_d;
  logic [D_SIZE-1:0]     lat_wdata_q, lat_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;

  // While idle the live request is the one being decided on (only matters when
  // WAIT_CYCLES = 0); afterwards the latched copy is authoritative.
  logic                  cur_we;
  size_e                 cur_size;
  logic [ADDR_LINE-1:0]  cur_addr;
  logic [D_SIZE-1:0]     cur_wdata;
  logic [LANE_W-1:0]     cur_lane;
  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_err;
  logic [NB-1:0]         cur_be;
  logic                  commit;
  logic                  arr_we, arr_re;
  logic [D_SIZE-1:0]     arr_rdata;
  logic [D_SIZE-1:0]     rd_shift;
  logic [D_SIZE-1:0]     rd_ext;

  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we    = req_we;
      cur_size  = size_e'(req_size);
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = lat_we_q;
      cur_size  = lat_size_q;
      cur_addr  = lat_addr_q;
      cur_wdata = lat_wdata_q;
    end
    cur_lane = cur_addr[LANE_W-1:0];
    cur_idx  = cur_addr[ADDR_LINE-1:LANE_W];

    cur_err = (32'(cur_idx) >= D_MEM);
    cur_be  = '0;
    case (cur_size)
      SZ_BYTE: cur_be = NB'(1) << cur_lane;
      SZ_HALF: begin
        cur_be = NB'(3) << cur_lane;
        if (cur_lane[0]) cur_err = 1'b1;
      end
      SZ_WORD: begin
        cur_be = '1;
        if (cur_lane != '0) cur_err = 1'b1;
      end
      default: cur_err = 1'b1;
    endcase
  end

  // The edge entering RESP is the one that touches the array.
  assign commit = ((state_q == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state_q == ST_WAIT) && (cnt_q == 4'd1));
  assign arr_we = commit &&  cur_we && !cur_err;
  assign arr_re = commit && !cur_we && !cur_err;

  dmem_array #(
    .D_SIZE (D_SIZE),
    .D_MEM  (D_MEM),
    .AW     (MEM_AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .be    (cur_be),
    .addr  (cur_idx[MEM_AW-1:0]),
    .wdata (cur_wdata << {cur_lane, 3'b000}),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lat_we_d       = lat_we_q;
    lat_size_d     = lat_size_q;
    lat_unsigned_d = lat_unsigned_q;
    lat_addr_d     = lat_addr_q;
    lat_wdata_d    = lat_wdata_q;
    resp_valid_d   = resp_valid_q;
    resp_err_d     = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lat_we_d       = req_we;
          lat_size_d     = size_e'(req_size);
          lat_unsigned_d = req_unsigned;
          lat_addr_d     = req_addr;
          lat_wdata_d    = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = cur_err;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d      = ST_RESP;
          cnt_d        = 4'd0;
          resp_valid_d = 1'b1;
          resp_err_d   = cur_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      lat_we_q       <= 1'b0;
      lat_size_q     <= SZ_BYTE;
      lat_unsigned_q <= 1'b0;
      lat_addr_q     <= '0;
      lat_wdata_q    <= '0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_we_q       <= lat_we_d;
      lat_size_q     <= lat_size_d;
      lat_unsigned_q <= lat_unsigned_d;
      lat_addr_q     <= lat_addr_d;
      lat_wdata_q    <= lat_wdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
    end
  end

  // Array read data is registered and held through RESP; extraction uses the
  // latched lane/size so the response stays stable under backpressure.
  always_comb begin
    rd_shift = arr_rdata >> {lat_addr_q[LANE_W-1:0], 3'b000};
    case (lat_size_q)
      SZ_BYTE: rd_ext = {{(D_SIZE-8){~lat_unsigned_q & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: rd_ext = {{(D_SIZE-16){~lat_unsigned_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = arr_rdata;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = (resp_valid_q && !resp_err_q && !lat_we_q) ? rd_ext : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int D_SIZE    = 32;
  localparam int ADDR_LINE = 13;
  localparam int D_MEM     = 1024;
  localparam int WAIT_CYC  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [ADDR_LINE-1:0] req_addr;
  logic [D_SIZE-1:0]    req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [D_SIZE-1:0]    resp_rdata;
  logic                 resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_ctrl #(
    .D_SIZE      (D_SIZE),
    .ADDR_LINE   (ADDR_LINE),
    .D_MEM       (D_MEM),
    .WAIT_CYCLES (WAIT_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits (bounded) for acceptance, then scrambles the
  // request inputs so the in-flight access must rely on its latched copy.
  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [ADDR_LINE-1:0] addr, input logic [31:0] wd);
    int guard;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    guard = 0;
    while (!req_ready && guard < 30) begin
      tick();
      guard++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = ADDR_LINE'($urandom);
    req_wdata    = $urandom;
  endtask

  // Called just after the accepting edge; latency counts the acceptance cycle.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!resp_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  task automatic get_resp(output int lat, output logic [31:0] rd, output logic err);
    wait_valid(lat);
    rd  = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [ADDR_LINE-1:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err);
    int lat;
    logic [31:0] rd;
    logic err;
    send(we, sz, uns, addr, wd);
    get_resp(lat, rd, err);
    check({tag, "_lat"}, 32'(lat), 32'(1 + WAIT_CYC));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  typedef struct {
    string              tag;
    logic               we;
    logic [1:0]         sz;
    logic               uns;
    logic [ADDR_LINE-1:0] addr;
    logic [31:0]        wd;
    logic [31:0]        rd;
    logic               err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    logic [31:0] hold_rd;

    reset = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b0;

    repeat (3) tick();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);

    //            tag          we    size   uns   addr      wdata          rdata          err
    vecs.push_back('{"st_w10",   1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, 32'h00000000, 1'b0});
    vecs.push_back('{"ld_w10",   1'b0, 2'b10, 1'b0, 13'h010, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{"st_b13",   1'b1, 2'b00, 1'b0, 13'h013, 32'h12345680, 32'h00000000, 1'b0});
    vecs.push_back('{"ld_sb13",  1'b0, 2'b00, 1'b0, 13'h013, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{"ld_ub13",  1'b0, 2'b00, 1'b1, 13'h013, 32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{"ld_w10b",  1'b0, 2'b10, 1'b0, 13'h010, 32'h0,        32'h80ADBEEF, 1'b0});
    vecs.push_back('{"ld_sh12",  1'b0, 2'b01, 1'b0, 13'h012, 32'h0,        32'hFFFF80AD, 1'b0});
    vecs.push_back('{"ld_uh10",  1'b0, 2'b01, 1'b1, 13'h010, 32'h0,        32'h0000BEEF, 1'b0});
    vecs.push_back('{"ld_sb11",  1'b0, 2'b00, 1'b0, 13'h011, 32'h0,        32'hFFFFFFBE, 1'b0});
    vecs.push_back('{"ld_ub10",  1'b0, 2'b00, 1'b1, 13'h010, 32'h0,        32'h000000EF, 1'b0});
    vecs.push_back('{"ld_h11",   1'b0, 2'b01, 1'b0, 13'h011, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{"ld_w12",   1'b0, 2'b10, 1'b0, 13'h012, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{"ld_sz11",  1'b0, 2'b11, 1'b0, 13'h010, 32'h0,        32'h00000000, 1'b1});
    vecs.push_back('{"ld_w10c",  1'b0, 2'b10, 1'b0, 13'h010, 32'h0,        32'h80ADBEEF, 1'b0});
    vecs.push_back('{"st_h16",   1'b1, 2'b01, 1'b0, 13'h016, 32'hAAAA1234, 32'h00000000, 1'b0});
    vecs.push_back('{"st_h15",   1'b1, 2'b01, 1'b0, 13'h015, 32'h0000FFFF, 32'h00000000, 1'b1});
    vecs.push_back('{"ld_w14",   1'b0, 2'b10, 1'b0, 13'h014, 32'h0,        32'h12340000, 1'b0});

    foreach (vecs[i])
      access(vecs[i].tag, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr,
             vecs[i].wd, vecs[i].rd, vecs[i].err);

    // Backpressure: response held while a new request waits.
    send(1'b0, 2'b10, 1'b0, 13'h010, 32'h0);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'(1 + WAIT_CYC));
    req_we = 1'b0;
    req_size = 2'b10;
    req_unsigned = 1'b0;
    req_addr = 13'h014;
    req_valid = 1'b1;
    hold_rd = 32'h80ADBEEF;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, hold_rd);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_after_hs_valid", 32'(resp_valid), 32'd0);
    check("bp_after_hs_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_addr = 13'h1F0;
    check("bp_next_accepted", 32'(req_ready), 32'd0);
    begin
      logic [31:0] rd;
      logic err;
      get_resp(lat, rd, err);
      check("bp_next_lat", 32'(lat), 32'(1 + WAIT_CYC));
      check("bp_next_rdata", rd, 32'h12340000);
    end

    // Reset while a store sits in WAIT.
    send(1'b1, 2'b10, 1'b0, 13'h020, 32'h12345678);
    check("rw_in_wait", 32'(req_ready), 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rw_req_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      check("rw_no_resp", 32'(resp_valid), 32'd0);
      tick();
    end
    access("rw_ld_w20", 1'b0, 2'b10, 1'b0, 13'h020, 32'h0, 32'h00000000, 1'b0);
    access("rw_ld_w10", 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 32'h00000000, 1'b0);

    // Index D_MEM is out of range and must not alias onto word 0.
    access("oor_st_w0",  1'b1, 2'b10, 1'b0, 13'h000,  32'h11111111, 32'h0, 1'b0);
    access("oor_st",     1'b1, 2'b10, 1'b0, 13'h1000, 32'hCAFEF00D, 32'h0, 1'b1);
    access("oor_ld",     1'b0, 2'b10, 1'b0, 13'h1000, 32'h0,        32'h0, 1'b1);
    access("oor_ld_w0",  1'b0, 2'b10, 1'b0, 13'h000,  32'h0, 32'h11111111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
